// File: rtl/sopc_run_ctrl_pkg.sv
// Shared definitions for the openmips SOPC run controller.
//   - run_state_e : controller state encoding (S_HOLD .. S_TIMEOUT)
//   - END_ADDR_DEFAULT : default signature store address
//   - STALL_FAIL_CODE  : fail_code reported by the stall detector
//   - `RstEnable / `RstDisable : openmips reset polarity (active-high)
// Optional feature macro: SOPC_RUN_STALL_DET_EN (used in sopc_run_ctrl.sv).

`ifndef RstEnable
`define RstEnable  1'b1
`endif
`ifndef RstDisable
`define RstDisable 1'b0
`endif

package sopc_run_ctrl_pkg;

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } run_state_e;

   localparam logic [31:0] END_ADDR_DEFAULT = 32'h0000_FFF0;
   localparam logic [31:0] STALL_FAIL_CODE  = 32'hDEAD_0001;

   function automatic logic is_terminal(input run_state_e s);
      return (s == S_PASS) || (s == S_FAIL) || (s == S_TIMEOUT);
   endfunction

endpackage

// File: rtl/sopc_run_ctrl_reg_watch.sv
// sopc_reg_watch: shadow copy of GPRs 0..NUM_WATCH-1 taken from the
// regfile write port, with a per-register "written since clear" bit.
// Ports:
//   clk, rst          clock, async active-low reset
//   clr               synchronous clear of all shadow data and valid bits
//   wr_en             capture enable (qualified write strobe)
//   wr_addr, wr_data  regfile write address / data
//   watch_data        flat shadow array, reg i at [i*DATA_W +: DATA_W]
//   watch_valid       bit i set once reg i has been captured
// Register 0 is never captured: $0 is hardwired to zero in the core.

module sopc_reg_watch #(
   parameter int NUM_WATCH = 8,
   parameter int DATA_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        wr_en,
   input  logic [4:0]                  wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   output logic [NUM_WATCH*DATA_W-1:0] watch_data,
   output logic [NUM_WATCH-1:0]        watch_valid
);

   logic [NUM_WATCH-1:0][DATA_W-1:0] data_q, data_d;
   logic [NUM_WATCH-1:0]             valid_q, valid_d;

   // Loop starts at 1 so $0 and any address outside the window fall through.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr) begin
         data_d  = '0;
         valid_d = '0;
      end else if (wr_en) begin
         for (int i = 1; i < NUM_WATCH; i++) begin
            if (wr_addr == 5'(i)) begin
               data_d[i]  = wr_data;
               valid_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign watch_data  = data_q;
   assign watch_valid = valid_q;

endmodule

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: run controller for the openmips minimal SOPC.
// Holds the core in reset for RST_HOLD_CYCLES edges, counts run cycles,
// shadows low GPRs, and ends the run on a store to END_ADDR (0 = PASS,
// otherwise FAIL with the stored value) or after TIMEOUT_CYCLES.
// Ports:
//   clk, rst           clock, async active-low reset
//   restart            pulse; rerun from a terminal state
//   core_rst           openmips reset (`RstEnable = asserted)
//   wb_we/waddr/wdata  regfile write port tap
//   mem_ce/we/addr/wdata  data-RAM port tap
//   done, pass, timeout, fail_code, cycle_count  run result
//   watch_data, watch_valid  shadow registers
// Optional feature macro: SOPC_RUN_STALL_DET_EN -- idle detector that
// fails the run after STALL_CYCLES RUN cycles without a regfile write.
//
// state     | meaning
// S_HOLD    | core held in reset, counting edges
// S_RUN     | core running, counting cycles
// S_PASS    | signature 0 stored, core halted
// S_FAIL    | nonzero signature (or stall), core halted
// S_TIMEOUT | TIMEOUT_CYCLES reached, core halted

module sopc_run_ctrl
   import sopc_run_ctrl_pkg::*;
#(
   parameter int          RST_HOLD_CYCLES = 4,
   parameter int          TIMEOUT_CYCLES  = 250,
   parameter int          NUM_WATCH       = 8,
   parameter int          DATA_W          = 32,
   parameter logic [31:0] END_ADDR        = END_ADDR_DEFAULT,
   parameter int          STALL_CYCLES    = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        restart,
   output logic                        core_rst,
   input  logic                        wb_we,
   input  logic [4:0]                  wb_waddr,
   input  logic [DATA_W-1:0]           wb_wdata,
   input  logic                        mem_ce,
   input  logic                        mem_we,
   input  logic [31:0]                 mem_addr,
   input  logic [DATA_W-1:0]           mem_wdata,
   output logic                        done,
   output logic                        pass,
   output logic                        timeout,
   output logic [DATA_W-1:0]           fail_code,
   output logic [31:0]                 cycle_count,
   output logic [NUM_WATCH*DATA_W-1:0] watch_data,
   output logic [NUM_WATCH-1:0]        watch_valid
);

   if (RST_HOLD_CYCLES < 1 || NUM_WATCH < 1 || NUM_WATCH > 32 ||
       TIMEOUT_CYCLES < 1 || STALL_CYCLES < 1) begin : g_bad_param
      $error("sopc_run_ctrl: parameter out of range");
   end

   localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES);

   run_state_e        state_q, state_d;
   logic [31:0]       hold_cnt_q, hold_cnt_d;
   logic [31:0]       cycle_q, cycle_d;
   logic              core_rst_q, core_rst_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [DATA_W-1:0] fail_code_q, fail_code_d;

   logic restart_acc;
   logic end_store;
   logic stall_hit;

   assign restart_acc = restart && is_terminal(state_q);
   assign end_store   = mem_ce && mem_we && (mem_addr == END_ADDR);

`ifdef SOPC_RUN_STALL_DET_EN
   logic [31:0] idle_q, idle_d;

   always_comb begin
      idle_d = '0;
      if (state_q == S_RUN && !wb_we) begin
         idle_d = idle_q + 32'd1;
      end
   end

   // Fires on the edge that would make the idle count reach STALL_CYCLES.
   assign stall_hit = (state_q == S_RUN) && !wb_we &&
                      (idle_q == 32'(STALL_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign stall_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      cycle_d     = cycle_q;
      core_rst_d  = core_rst_q;
      done_d      = done_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      fail_code_d = fail_code_q;

      unique case (state_q)
         S_HOLD: begin
            core_rst_d = `RstEnable;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = S_RUN;
               hold_cnt_d = '0;
               cycle_d    = 32'd1;
               core_rst_d = `RstDisable;
            end else begin
               hold_cnt_d = hold_cnt_q + 32'd1;
            end
         end
         S_RUN: begin
            // cycle_count freezes on the exit edge so it reports the last RUN cycle.
            if (end_store) begin
               done_d     = 1'b1;
               core_rst_d = `RstEnable;
               if (mem_wdata == '0) begin
                  state_d = S_PASS;
                  pass_d  = 1'b1;
               end else begin
                  state_d     = S_FAIL;
                  fail_code_d = mem_wdata;
               end
            end else if (cycle_q == TO_LAST) begin
               state_d    = S_TIMEOUT;
               done_d     = 1'b1;
               timeout_d  = 1'b1;
               core_rst_d = `RstEnable;
            end else if (stall_hit) begin
               state_d     = S_FAIL;
               done_d      = 1'b1;
               fail_code_d = DATA_W'(STALL_FAIL_CODE);
               core_rst_d  = `RstEnable;
            end else begin
               cycle_d = cycle_q + 32'd1;
            end
         end
         default: begin
            if (restart_acc) begin
               state_d     = S_HOLD;
               hold_cnt_d  = '0;
               cycle_d     = '0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               timeout_d   = 1'b0;
               fail_code_d = '0;
               core_rst_d  = `RstEnable;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_HOLD;
         hold_cnt_q  <= '0;
         cycle_q     <= '0;
         core_rst_q  <= `RstEnable;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         fail_code_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         cycle_q     <= cycle_d;
         core_rst_q  <= core_rst_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         fail_code_q <= fail_code_d;
      end
   end

   sopc_reg_watch #(
      .NUM_WATCH (NUM_WATCH),
      .DATA_W    (DATA_W)
   ) u_reg_watch (
      .clk         (clk),
      .rst         (rst),
      .clr         (restart_acc),
      .wr_en       (wb_we && (state_q == S_RUN)),
      .wr_addr     (wb_waddr),
      .wr_data     (wb_wdata),
      .watch_data  (watch_data),
      .watch_valid (watch_valid)
   );

   assign core_rst    = core_rst_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign fail_code   = fail_code_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Self-checking bench for sopc_run_ctrl (default build, default parameters).
module tb_sopc_run_ctrl;
   localparam int          NW   = 8;
   localparam int          DW   = 32;
   localparam int          HOLD = 4;
   localparam int          TO   = 250;
   localparam logic [31:0] EA   = 32'h0000_FFF0;

   logic             clk = 1'b0;
   logic             rst;
   logic             restart;
   logic             core_rst;
   logic             wb_we;
   logic [4:0]       wb_waddr;
   logic [DW-1:0]    wb_wdata;
   logic             mem_ce, mem_we;
   logic [31:0]      mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic             done, pass, timeout;
   logic [DW-1:0]    fail_code;
   logic [31:0]      cycle_count;
   logic [NW*DW-1:0] watch_data;
   logic [NW-1:0]    watch_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sopc_run_ctrl dut (
      .clk(clk), .rst(rst), .restart(restart), .core_rst(core_rst),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code),
      .cycle_count(cycle_count), .watch_data(watch_data), .watch_valid(watch_valid)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = core held in reset, 1 = program running, 2 = run over
   int          m_phase;
   int          m_edges;
   int          m_cyc;
   bit          m_done, m_pass, m_to;
   logic [31:0] m_fc;
   logic [31:0] m_sh [NW];
   bit   [NW-1:0] m_val;

   task automatic model_clear();
      m_phase = 0; m_edges = 0; m_cyc = 0;
      m_done = 0; m_pass = 0; m_to = 0; m_fc = 0; m_val = '0;
      for (int i = 0; i < NW; i++) m_sh[i] = 0;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_clear();
      end else if (m_phase == 0) begin
         m_edges++;
         if (m_edges == HOLD) begin
            m_phase = 1;
            m_cyc   = 1;
         end
      end else if (m_phase == 1) begin
         if (wb_we && wb_waddr >= 1 && wb_waddr < NW) begin
            m_sh[wb_waddr]  = wb_wdata;
            m_val[wb_waddr] = 1'b1;
         end
         if (mem_ce && mem_we && mem_addr == EA) begin
            m_phase = 2; m_done = 1;
            m_pass  = (mem_wdata == 0);
            m_fc    = mem_wdata;
         end else if (m_cyc == TO) begin
            m_phase = 2; m_done = 1; m_to = 1;
         end else begin
            m_cyc++;
         end
      end else if (restart) begin
         model_clear();
      end
   end

   always @(negedge clk) begin
      logic [NW*DW-1:0] exp_wd;
      for (int i = 0; i < NW; i++) exp_wd[i*DW +: DW] = m_sh[i];
      chk("core_rst",    core_rst,    (m_phase != 1));
      chk("done",        done,        m_done);
      chk("pass",        pass,        m_pass);
      chk("timeout",     timeout,     m_to);
      chk("fail_code",   fail_code,   m_fc);
      chk("cycle_count", cycle_count, m_cyc);
      chk("watch_data",  watch_data,  exp_wd);
      chk("watch_valid", watch_valid, m_val);
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      restart = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
      mem_ce = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] val);
      mem_ce = 1; mem_we = 1; mem_addr = addr; mem_wdata = val;
   endtask

   task automatic wait_run();
      int n = 0;
      while (core_rst !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      chk("wait_run_entry", core_rst, 1'b0);
   endtask

   task automatic wait_cycle(input int target);
      int n = 0;
      while (cycle_count !== 32'(target) && n < 400) begin @(negedge clk); n++; end
      chk("wait_cycle_reached", cycle_count, target);
   endtask

   task automatic pulse_restart();
      restart = 1;
      @(negedge clk);
      restart = 0;
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("lit_rst_core_rst", core_rst, 1);
      chk("lit_rst_cycle", cycle_count, 0);
      rst = 1;

      // hold phase: exactly 4 edges with core_rst asserted
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("lit_hold_core_rst", core_rst, 1);
      end
      @(negedge clk);
      chk("lit_run_core_rst", core_rst, 0);
      chk("lit_run_first_cycle", cycle_count, 1);

      // watch window: reg 3 captured, $0 and reg 9 ignored, restart in RUN ignored
      wb_we = 1; wb_waddr = 3; wb_wdata = 32'h1234;
      @(negedge clk);
      chk("lit_watch3_data", watch_data[3*DW +: DW], 32'h1234);
      chk("lit_watch3_valid", watch_valid, 8'b0000_1000);
      wb_waddr = 0; wb_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      wb_waddr = 9; wb_wdata = 32'h0BAD_0BAD; restart = 1;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      chk("lit_watch_no_change", watch_valid, 8'b0000_1000);
      chk("lit_watch0_zero", watch_data[0 +: DW], 0);
      chk("lit_restart_in_run", done, 0);

      // PASS at run cycle 20, with a regfile write on the same edge
      wait_cycle(20);
      store(EA, 0);
      wb_we = 1; wb_waddr = 5; wb_wdata = 32'hA5;
      @(negedge clk);
      idle_inputs();
      chk("lit_pass_done", done, 1);
      chk("lit_pass_pass", pass, 1);
      chk("lit_pass_core_rst", core_rst, 1);
      chk("lit_pass_cycle", cycle_count, 20);
      chk("lit_pass_valid", watch_valid, 8'b0010_1000);
      // activity in the terminal state is ignored
      store(EA, 7); wb_we = 1; wb_waddr = 6; wb_wdata = 32'h66;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      chk("lit_frozen_fc", fail_code, 0);
      chk("lit_frozen_valid", watch_valid, 8'b0010_1000);

      // restart from PASS clears everything
      pulse_restart();
      chk("lit_restart_done", done, 0);
      chk("lit_restart_pass", pass, 0);
      chk("lit_restart_cycle", cycle_count, 0);
      chk("lit_restart_valid", watch_valid, 0);
      chk("lit_restart_core_rst", core_rst, 1);

      // FAIL run: near-miss stores first, then signature 5
      wait_run();
      store(EA + 4, 9);
      @(negedge clk);
      mem_we = 0; mem_addr = EA; mem_wdata = 3;
      @(negedge clk);
      idle_inputs();
      wait_cycle(10);
      store(EA, 5);
      @(negedge clk);
      idle_inputs();
      chk("lit_fail_done", done, 1);
      chk("lit_fail_pass", pass, 0);
      chk("lit_fail_code", fail_code, 5);
      chk("lit_fail_cycle", cycle_count, 10);

      // TIMEOUT run
      pulse_restart();
      wait_run();
      begin
         int n = 0;
         while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      end
      chk("lit_to_done", done, 1);
      chk("lit_to_timeout", timeout, 1);
      chk("lit_to_cycle", cycle_count, 250);
      chk("lit_to_pass", pass, 0);

      // end store on the timeout edge wins
      pulse_restart();
      wait_run();
      wait_cycle(TO);
      store(EA, 0);
      @(negedge clk);
      idle_inputs();
      chk("lit_tie_pass", pass, 1);
      chk("lit_tie_timeout", timeout, 0);
      chk("lit_tie_cycle", cycle_count, 250);

      // async reset mid-run, no clock edge in between
      pulse_restart();
      wait_run();
      repeat (5) @(negedge clk);
      #2 rst = 0;
      #1;
      chk("lit_async_core_rst", core_rst, 1);
      chk("lit_async_cycle", cycle_count, 0);
      @(negedge clk);
      rst = 1;
      repeat (8) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
